// File: rtl/sha512_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha512_stream: packs IN_W-bit beats into 1024-bit blocks for an inner SHA-512
// core. Define SHA512_STREAM_STATS_EN for block/message counters.  Rev 1.0
// ---------------------------------------------------------------------------

module sha512_core (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          next,
  input  logic [1:0]    mode,
  input  logic [1023:0] block,
  output logic          ready,
  output logic [511:0]  digest,
  output logic          digest_valid
);
  localparam logic [0:79][63:0] c_k = {
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};
  localparam logic [511:0] c_iv512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [511:0] c_iv384 = {
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};

  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  logic [63:0]  r_h [8];
  logic [63:0]  r_v [8];
  logic [63:0]  r_w [16];
  logic [6:0]   r_round;
  logic         r_running;
  logic         r_digest_valid;
  logic [63:0]  w_t1, w_t2, w_new;
  logic [511:0] w_iv;

  assign w_iv         = (mode == 2'd2) ? c_iv384 : c_iv512;
  assign ready        = !r_running;
  assign digest_valid = r_digest_valid;
  assign digest       = {r_h[0], r_h[1], r_h[2], r_h[3], r_h[4], r_h[5], r_h[6], r_h[7]};

  // r_w[0] is always W[t]; the window slides one word per round.
  always_comb begin
    w_t1  = r_v[7] + (ror(r_v[4], 14) ^ ror(r_v[4], 18) ^ ror(r_v[4], 41))
          + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6])) + c_k[r_round] + r_w[0];
    w_t2  = (ror(r_v[0], 28) ^ ror(r_v[0], 34) ^ ror(r_v[0], 39))
          + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
    w_new = (ror(r_w[14], 19) ^ ror(r_w[14], 61) ^ (r_w[14] >> 6)) + r_w[9]
          + (ror(r_w[1], 1) ^ ror(r_w[1], 8) ^ (r_w[1] >> 7)) + r_w[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_h[i] <= '0;
        r_v[i] <= '0;
      end
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
      r_round        <= '0;
      r_running      <= 1'b0;
      r_digest_valid <= 1'b0;
    end else if (r_running) begin
      r_v[0] <= w_t1 + w_t2;
      r_v[1] <= r_v[0];
      r_v[2] <= r_v[1];
      r_v[3] <= r_v[2];
      r_v[4] <= r_v[3] + w_t1;
      r_v[5] <= r_v[4];
      r_v[6] <= r_v[5];
      r_v[7] <= r_v[6];
      for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
      r_w[15] <= w_new;
      r_round <= r_round + 7'd1;
      if (r_round == 7'd79) begin
        r_round        <= '0;
        r_running      <= 1'b0;
        r_digest_valid <= 1'b1;
        r_h[0] <= r_h[0] + w_t1 + w_t2;
        r_h[1] <= r_h[1] + r_v[0];
        r_h[2] <= r_h[2] + r_v[1];
        r_h[3] <= r_h[3] + r_v[2];
        r_h[4] <= r_h[4] + r_v[3] + w_t1;
        r_h[5] <= r_h[5] + r_v[4];
        r_h[6] <= r_h[6] + r_v[5];
        r_h[7] <= r_h[7] + r_v[6];
      end
    end else if (init || next) begin
      for (int i = 0; i < 8; i++) begin
        r_h[i] <= init ? w_iv[511-64*i -: 64] : r_h[i];
        r_v[i] <= init ? w_iv[511-64*i -: 64] : r_h[i];
      end
      for (int i = 0; i < 16; i++) r_w[i] <= block[1023-64*i -: 64];
      r_round        <= '0;
      r_running      <= 1'b1;
      r_digest_valid <= 1'b0;
    end
  end
endmodule

module sha512_stream #(
  parameter int unsigned IN_W      = 512,
  parameter logic [1:0]  CORE_MODE = 2'd3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [511:0]    out_digest,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            err_last
`ifdef SHA512_STREAM_STATS_EN
  ,
  output logic [31:0]     stat_blocks,
  output logic [31:0]     stat_msgs
`endif
);
  localparam int                 c_beats     = 1024 / IN_W;
  localparam int                 c_cnt_w     = $clog2(c_beats);
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(c_beats - 1);

  typedef enum logic [1:0] {FILL = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, OUT = 2'd3} state_t;

  state_t             r_state, w_state_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic [1023:0]      r_block;
  logic [511:0]       r_out_digest, w_core_digest;
  logic r_first, r_last_blk, r_wait_first, r_out_valid, r_err_last;
  logic w_beat_acc, w_core_init, w_core_next, w_core_ready, w_core_digest_valid;

  assign w_beat_acc = in_valid && (r_state == FILL);
  assign out_digest = r_out_digest;
  assign out_valid  = r_out_valid;
  assign err_last   = r_err_last;
  assign busy       = (r_state != FILL) || (r_cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FILL;
    else       r_state <= w_state_next;
  end

  // The core only lowers ready after seeing the pulse, so the first WAIT cycle is skipped.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    w_core_init  = 1'b0;
    w_core_next  = 1'b0;
    case (r_state)
      FILL: begin
        in_ready = 1'b1;
        if (w_beat_acc && r_cnt == c_last_beat) w_state_next = ISSUE;
      end
      ISSUE: begin
        w_core_init  = r_first;
        w_core_next  = !r_first;
        w_state_next = WAIT;
      end
      WAIT: begin
        if (!r_wait_first && w_core_ready) begin
          if (!r_last_blk)              w_state_next = FILL;
          else if (w_core_digest_valid) w_state_next = OUT;
        end
      end
      OUT:     if (out_ready) w_state_next = FILL;
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_block      <= '0;
      r_first      <= 1'b1;
      r_last_blk   <= 1'b0;
      r_wait_first <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_digest <= '0;
      r_err_last   <= 1'b0;
    end else begin
      r_wait_first <= (r_state == ISSUE);
      if (w_beat_acc) begin
        for (int k = 0; k < c_beats; k++)
          if (r_cnt == c_cnt_w'(k)) r_block[1023-k*IN_W -: IN_W] <= in_data;
        if (r_cnt == c_last_beat) begin
          r_cnt      <= '0;
          r_last_blk <= in_last;
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
          if (in_last) r_err_last <= 1'b1;
        end
      end
      if (r_state == ISSUE) r_first <= 1'b0;
      if (r_state == WAIT && w_state_next == OUT) begin
        r_out_digest <= w_core_digest;
        r_out_valid  <= 1'b1;
      end
      if (r_state == OUT && out_ready) begin
        r_out_valid <= 1'b0;
        r_first     <= 1'b1;
      end
    end
  end

`ifdef SHA512_STREAM_STATS_EN
  logic [31:0] r_stat_blocks, r_stat_msgs;
  assign stat_blocks = r_stat_blocks;
  assign stat_msgs   = r_stat_msgs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_blocks <= '0;
      r_stat_msgs   <= '0;
    end else begin
      if (w_core_init || w_core_next)  r_stat_blocks <= r_stat_blocks + 32'd1;
      if (r_state == OUT && out_ready) r_stat_msgs   <= r_stat_msgs + 32'd1;
    end
  end
`endif

  sha512_core u_core (
    .clk          (clk),
    .reset        (reset),
    .init         (w_core_init),
    .next         (w_core_next),
    .mode         (CORE_MODE),
    .block        (r_block),
    .ready        (w_core_ready),
    .digest       (w_core_digest),
    .digest_valid (w_core_digest_valid)
  );
endmodule

`default_nettype wire

// File: tb/tb_sha512_stream.sv
`default_nettype none
`timescale 1ns/1ps
// Directed bench for sha512_stream at IN_W = 512 (a), 64 (b) and 128 (c).
module tb_sha512_stream;
  localparam logic [1023:0] ABC    = {32'h61626380, 928'h0, 64'h18};
  localparam logic [511:0]  ABC_D  = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
  localparam logic [511:0]  TWO_D  = 512'h8e959b75dae313da8cf4f72814fc143f8f7779c6eb9f7fa17299aeadb6889018501d289e4900f7e4331b99dec4b5433ac7d329eeb6dd26545e96e55b874be909;
  localparam logic [895:0]  MSG2   = "abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmnhijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu";
  localparam logic [1023:0] BLK1   = {MSG2, 8'h80, 120'h0};
  localparam logic [1023:0] BLK2   = 1024'd896;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [511:0] in_data_a;
  logic [63:0]  in_data_b;
  logic [127:0] in_data_c;
  logic [2:0]   in_valid, in_last, out_ready;
  wire  [2:0]   in_ready, out_valid, busy, err_last;
  wire  [511:0] dig_a, dig_b, dig_c;
  int errors = 0, checks = 0;
  int init_a = 0, next_a = 0, init_c = 0, next_c = 0;

`ifdef SHA512_STREAM_STATS_EN
  wire [31:0] sb_a, sm_a, sb_b, sm_b, sb_c, sm_c;
`endif

  sha512_stream #(.IN_W(512)) dut_a (
    .clk(clk), .reset(reset), .in_data(in_data_a), .in_valid(in_valid[0]), .in_last(in_last[0]),
    .in_ready(in_ready[0]), .out_digest(dig_a), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .busy(busy[0]), .err_last(err_last[0])
`ifdef SHA512_STREAM_STATS_EN
    , .stat_blocks(sb_a), .stat_msgs(sm_a)
`endif
  );
  sha512_stream #(.IN_W(64)) dut_b (
    .clk(clk), .reset(reset), .in_data(in_data_b), .in_valid(in_valid[1]), .in_last(in_last[1]),
    .in_ready(in_ready[1]), .out_digest(dig_b), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .busy(busy[1]), .err_last(err_last[1])
`ifdef SHA512_STREAM_STATS_EN
    , .stat_blocks(sb_b), .stat_msgs(sm_b)
`endif
  );
  sha512_stream #(.IN_W(128)) dut_c (
    .clk(clk), .reset(reset), .in_data(in_data_c), .in_valid(in_valid[2]), .in_last(in_last[2]),
    .in_ready(in_ready[2]), .out_digest(dig_c), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .busy(busy[2]), .err_last(err_last[2])
`ifdef SHA512_STREAM_STATS_EN
    , .stat_blocks(sb_c), .stat_msgs(sm_c)
`endif
  );

  // Core start pulses, sampled mid-cycle where ISSUE is stable.
  always @(negedge clk) begin
    if (dut_a.w_core_init) init_a++;
    if (dut_a.w_core_next) next_a++;
    if (dut_c.w_core_init) init_c++;
    if (dut_c.w_core_next) next_c++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check512(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] dig_of(input int sel);
    return (sel == 0) ? dig_a : (sel == 1) ? dig_b : dig_c;
  endfunction

  task automatic send_block(input int sel, input logic [1023:0] blk, input bit last,
                            input int err_beat, input bit gaps);
    int nb;
    nb = (sel == 0) ? 2 : (sel == 1) ? 16 : 8;
    for (int k = 0; k < nb; k++) begin
      int t;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      case (sel)
        0:       in_data_a = blk[1023-k*512 -: 512];
        1:       in_data_b = blk[1023-k*64 -: 64];
        default: in_data_c = blk[1023-k*128 -: 128];
      endcase
      in_valid[sel] = 1'b1;
      in_last[sel]  = (last && k == nb - 1) || (k == err_beat);
      t = 0;
      while (!in_ready[sel] && t < 1000) begin
        tick();
        t++;
      end
      if (t >= 1000) check1("send_in_ready_timeout", in_ready[sel], 1'b1);
      tick();
      in_valid[sel] = 1'b0;
      in_last[sel]  = 1'b0;
    end
  endtask

  task automatic get_digest(input int sel, input logic [511:0] exp, input string tag);
    int t;
    t = 0;
    while (!out_valid[sel] && t < 400) begin
      tick();
      t++;
    end
    check1({tag, "_valid"}, out_valid[sel], 1'b1);
    check512(tag, dig_of(sel), exp);
    out_ready[sel] = 1'b1;
    tick();
    out_ready[sel] = 1'b0;
    check1({tag, "_drop"}, out_valid[sel], 1'b0);
  endtask

  initial begin
    bit ok, rdy_low;
    int t;
    reset = 1'b1;
    in_valid = '0; in_last = '0; out_ready = '0;
    in_data_a = '0; in_data_b = '0; in_data_c = '0;
    repeat (3) tick();
    check1("rst_in_ready", in_ready[0], 1'b1);
    check1("rst_out_valid", out_valid[0], 1'b0);
    check512("rst_digest", dig_a, 512'h0);
    check1("rst_busy", busy[0], 1'b0);
    check1("rst_err_last", err_last[0], 1'b0);
    reset = 1'b0;
    tick();
    check1("post_rst_in_ready", in_ready[0], 1'b1);

    // One-block "abc" at 512-bit beats
    send_block(0, ABC, 1'b1, -1, 1'b0);
    get_digest(0, ABC_D, "a_abc");
    checkn("a_abc_init", init_a, 1);
    checkn("a_abc_next", next_a, 0);

    // Digest held under backpressure; a beat offered in OUT must not be taken
    send_block(0, ABC, 1'b1, -1, 1'b0);
    t = 0;
    while (!out_valid[0] && t < 400) begin
      tick();
      t++;
    end
    check1("hold_valid", out_valid[0], 1'b1);
    in_data_a = '1;
    in_valid[0] = 1'b1;
    ok = 1'b1;
    rdy_low = 1'b1;
    repeat (50) begin
      tick();
      if (!out_valid[0] || dig_a !== ABC_D) ok = 1'b0;
      if (in_ready[0]) rdy_low = 1'b0;
    end
    check1("hold_stable", ok, 1'b1);
    check1("hold_in_ready_low", rdy_low, 1'b1);
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b0;
    check1("hold_release_valid", out_valid[0], 1'b0);
    check1("hold_beat_not_taken", busy[0], 1'b0);
    send_block(0, ABC, 1'b1, -1, 1'b0);
    get_digest(0, ABC_D, "a_after_hold");
    checkn("a_after_hold_init", init_a, 3);
    checkn("a_after_hold_next", next_a, 0);

    // "abc" as 16 beats of 64 bits with random gaps
    send_block(1, ABC, 1'b1, -1, 1'b1);
    rdy_low = 1'b1;
    t = 0;
    while (!out_valid[1] && t < 400) begin
      if (in_ready[1]) rdy_low = 1'b0;
      tick();
      t++;
    end
    check1("b_in_ready_low", rdy_low, 1'b1);
    get_digest(1, ABC_D, "b_abc");
    check1("b_in_ready_back", in_ready[1], 1'b1);

    // Two-block message followed by "abc" at 128-bit beats
    send_block(2, BLK1, 1'b0, -1, 1'b0);
    send_block(2, BLK2, 1'b1, -1, 1'b0);
    get_digest(2, TWO_D, "c_two");
    send_block(2, ABC, 1'b1, -1, 1'b0);
    get_digest(2, ABC_D, "c_abc");
    checkn("c_init", init_c, 2);
    checkn("c_next", next_c, 1);
`ifdef SHA512_STREAM_STATS_EN
    checkn("c_stat_blocks", int'(sb_c), 3);
    checkn("c_stat_msgs", int'(sm_c), 2);
`endif

    // in_last on a non-final beat: sticky error, block not treated as final
    send_block(0, ABC, 1'b0, 0, 1'b0);
    check1("err_set", err_last[0], 1'b1);
    ok = 1'b1;
    t = 0;
    while (busy[0] && t < 400) begin
      if (out_valid[0]) ok = 1'b0;
      tick();
      t++;
    end
    check1("err_back_to_fill", busy[0], 1'b0);
    check1("err_no_digest", ok, 1'b1);
    check1("err_sticky", err_last[0], 1'b1);

    // Reset in the middle of WAIT
    send_block(0, ABC, 1'b1, -1, 1'b0);
    repeat (20) tick();
    check1("midwait_busy", busy[0], 1'b1);
    checkn("midwait_init", init_a, 4);
    checkn("midwait_next", next_a, 1);
    reset = 1'b1;
    #2;
    check1("arst_in_ready", in_ready[0], 1'b1);
    check1("arst_out_valid", out_valid[0], 1'b0);
    check512("arst_digest", dig_a, 512'h0);
    check1("arst_busy", busy[0], 1'b0);
    check1("arst_err_last", err_last[0], 1'b0);
    tick();
    reset = 1'b0;
    ok = 1'b1;
    repeat (150) begin
      tick();
      if (out_valid[0]) ok = 1'b0;
    end
    check1("arst_no_digest", ok, 1'b1);
    send_block(0, ABC, 1'b1, -1, 1'b0);
    get_digest(0, ABC_D, "a_after_reset");
    checkn("a_after_reset_init", init_a, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
